// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game datapath.
package snake_pkg;

  localparam int unsigned GRID_N  = 8;
  localparam int unsigned COORD_W = 3;
  localparam int unsigned CELL_W  = 6;

  // Fibonacci taps q[7]^q[5]^q[4]^q[3]
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SCAN
  } spawn_state_t;

endpackage

// File: rtl/food_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; advances every cycle out of reset.
module food_lfsr
  import snake_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  logic feedback;

  always_comb feedback = ^(q & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (!rst_n) q <= SEED;
    else        q <= {q[6:0], feedback};
  end

endmodule

// File: rtl/food_spawner.sv
// Picks a free board cell for new food: random LFSR probes, then a wrapping linear scan.
module food_spawner
  import snake_pkg::*;
#(
  parameter logic [7:0]  SEED      = 8'hA5,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spawn_req,
  input  logic               collide,
  output logic [COORD_W-1:0] coord_x,
  output logic [COORD_W-1:0] coord_y,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               busy,
  output logic               board_full
);

  localparam logic [7:0] TRIES_LIMIT = MAX_TRIES[7:0];
  localparam logic [6:0] SCAN_LIMIT  = 7'(GRID_N * GRID_N);

  spawn_state_t      state, state_n;
  logic [7:0]        lfsr_q;
  logic [7:0]        tries, tries_n;
  logic [6:0]        scan_cnt, scan_cnt_n;
  logic [CELL_W-1:0] coord, coord_n;
  logic [CELL_W-1:0] food, food_n;
  logic              food_valid_n, busy_n, board_full_n;
  logic [CELL_W-1:0] candidate;
  logic              lfsr_unused;

  food_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .q    (lfsr_q)
  );

  // Cell index is {y, x}, so +1 walks row-major and wraps 63 -> 0
  always_comb candidate   = lfsr_q[CELL_W-1:0];
  always_comb lfsr_unused = ^lfsr_q[7:CELL_W];

  always_comb begin
    state_n      = state;
    tries_n      = tries;
    scan_cnt_n   = scan_cnt;
    coord_n      = coord;
    food_n       = food;
    food_valid_n = food_valid;
    busy_n       = busy;
    board_full_n = 1'b0;
    case (state)
      IDLE: begin
        if (spawn_req) begin
          coord_n      = candidate;
          food_valid_n = 1'b0;
          busy_n       = 1'b1;
          tries_n      = 8'd1;
          state_n      = CHECK;
        end
      end
      CHECK: begin
        if (!collide) begin
          food_n       = coord;
          food_valid_n = 1'b1;
          busy_n       = 1'b0;
          state_n      = IDLE;
        end else if (tries < TRIES_LIMIT) begin
          coord_n = candidate;
          tries_n = tries + 8'd1;
        end else begin
          coord_n    = coord + 6'd1;
          scan_cnt_n = 7'd1;
          state_n    = SCAN;
        end
      end
      SCAN: begin
        if (!collide) begin
          food_n       = coord;
          food_valid_n = 1'b1;
          busy_n       = 1'b0;
          state_n      = IDLE;
        end else if (scan_cnt < SCAN_LIMIT) begin
          coord_n    = coord + 6'd1;
          scan_cnt_n = scan_cnt + 7'd1;
        end else begin
          board_full_n = 1'b1;
          busy_n       = 1'b0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tries      <= '0;
      scan_cnt   <= '0;
      coord      <= '0;
      food       <= '0;
      food_valid <= 1'b0;
      busy       <= 1'b0;
      board_full <= 1'b0;
    end else begin
      state      <= state_n;
      tries      <= tries_n;
      scan_cnt   <= scan_cnt_n;
      coord      <= coord_n;
      food       <= food_n;
      food_valid <= food_valid_n;
      busy       <= busy_n;
      board_full <= board_full_n;
    end
  end

  always_comb begin
    coord_x = coord[COORD_W-1:0];
    coord_y = coord[CELL_W-1:COORD_W];
    food_x  = food[COORD_W-1:0];
    food_y  = food[CELL_W-1:COORD_W];
  end

endmodule

// File: tb/tb_food_spawner.sv
// Directed self-checking bench for food_spawner with a behavioural collision detector.
module tb_food_spawner;

  localparam logic [7:0] SEED = 8'hA5;
  localparam int         MAXT = 8;

  logic       clk = 1'b0;
  logic       rst_n, spawn_req, collide;
  logic [2:0] coord_x, coord_y, food_x, food_y;
  logic       food_valid, busy, board_full;
  logic [7:0] board [8];
  logic [7:0] m;
  int         tests = 0;
  int         fails = 0;

  food_spawner #(.SEED(SEED), .MAX_TRIES(MAXT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spawn_req (spawn_req),
    .collide   (collide),
    .coord_x   (coord_x),
    .coord_y   (coord_y),
    .food_x    (food_x),
    .food_y    (food_y),
    .food_valid(food_valid),
    .busy      (busy),
    .board_full(board_full)
  );

  always #5 clk = ~clk;

  // x=0 is the row MSB
  assign collide = board[coord_y][~coord_x];

  // Reference LFSR straight from the polynomial
  always @(posedge clk) begin
    if (!rst_n) m <= SEED;
    else        m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_board(input logic [7:0] v);
    for (int r = 0; r < 8; r++) board[r] = v;
  endtask

  // Runs one search for budget edges, collecting timing and coord-sequence errors.
  task automatic run_search(input int budget, input int req_lo, input int req_hi,
                            output int done_edge, output int full_pulses,
                            output int busy_err, output int seq_err);
    logic [7:0] pm;
    logic [5:0] prev, exp_c;
    done_edge = 0; full_pulses = 0; busy_err = 0; seq_err = 0;
    pm = m;
    prev = '0;
    spawn_req = 1'b1;
    for (int e = 1; e <= budget; e++) begin
      tick();
      if (board_full) begin
        full_pulses++;
        if (done_edge == 0) done_edge = e;
      end
      if (food_valid && done_edge == 0) done_edge = e;
      if (done_edge == 0) begin
        if (!busy) busy_err++;
        exp_c = (e <= MAXT) ? pm[5:0] : prev + 6'd1;
        if ({coord_y, coord_x} !== exp_c) seq_err++;
        prev = {coord_y, coord_x};
      end
      pm = m;
      spawn_req = (e + 1 >= req_lo) && (e + 1 <= req_hi);
    end
    spawn_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spawn_req = 1'b0; set_board(8'h00);
    tick(); tick();
    tests++; if ({coord_y, coord_x} !== 6'd0) begin fails++; $display("FAIL reset_coord: got %0h expected 0", {coord_y, coord_x}); end
    tests++; if ({food_y, food_x} !== 6'd0) begin fails++; $display("FAIL reset_food: got %0h expected 0", {food_y, food_x}); end
    tests++; if (food_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", food_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (board_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", board_full); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_empty_spawn();
    logic [7:0] cap;
    set_board(8'h00);
    cap = m;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    tests++; if (busy !== 1'b1 || food_valid !== 1'b0) begin fails++; $display("FAIL empty_edge1: got busy=%b valid=%b expected busy=1 valid=0", busy, food_valid); end
    tests++; if ({coord_y, coord_x} !== cap[5:0]) begin fails++; $display("FAIL empty_cand: got %0h expected %0h", {coord_y, coord_x}, cap[5:0]); end
    tick();
    tests++; if (food_valid !== 1'b1) begin fails++; $display("FAIL empty_valid: got %b expected 1", food_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL empty_busy: got %b expected 0", busy); end
    tests++; if ({food_y, food_x} !== cap[5:0]) begin fails++; $display("FAIL empty_food: got %0h expected %0h", {food_y, food_x}, cap[5:0]); end
  endtask

  task automatic test_full_board();
    int done_e, nfull, berr, serr;
    set_board(8'hFF);
    run_search(85, 0, 0, done_e, nfull, berr, serr);
    tests++; if (done_e !== 73) begin fails++; $display("FAIL full_latency: got %0d expected 73", done_e); end
    tests++; if (nfull !== 1) begin fails++; $display("FAIL full_pulses: got %0d expected 1", nfull); end
    tests++; if (berr !== 0) begin fails++; $display("FAIL full_busy: got %0d busy drops expected 0", berr); end
    tests++; if (serr !== 0) begin fails++; $display("FAIL full_coord_seq: got %0d errors expected 0", serr); end
    tests++; if (food_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL full_after: got valid=%b busy=%b expected 0 0", food_valid, busy); end
  endtask

  task automatic test_scan_find();
    int done_e, nfull, berr, serr;
    set_board(8'hFF);
    board[3] = 8'hDF;
    run_search(80, 0, 0, done_e, nfull, berr, serr);
    tests++; if (done_e < 2 || done_e > 73) begin fails++; $display("FAIL find_latency: got %0d expected 2..73", done_e); end
    tests++; if (food_valid !== 1'b1) begin fails++; $display("FAIL find_valid: got %b expected 1", food_valid); end
    tests++; if (food_x !== 3'd2 || food_y !== 3'd3) begin fails++; $display("FAIL find_pos: got x=%0d y=%0d expected x=2 y=3", food_x, food_y); end
    tests++; if (serr !== 0) begin fails++; $display("FAIL find_coord_seq: got %0d errors expected 0", serr); end
    tests++; if (nfull !== 0) begin fails++; $display("FAIL find_full: got %0d pulses expected 0", nfull); end
  endtask

  task automatic test_ignored_requests();
    int done_e, nfull, berr, serr;
    set_board(8'hFF);
    run_search(85, 2, 5, done_e, nfull, berr, serr);
    tests++; if (done_e !== 73) begin fails++; $display("FAIL ignore_latency: got %0d expected 73", done_e); end
    tests++; if (nfull !== 1) begin fails++; $display("FAIL ignore_pulses: got %0d expected 1", nfull); end
    tests++; if (serr !== 0 || berr !== 0) begin fails++; $display("FAIL ignore_seq: got seq=%0d busy=%0d errors expected 0 0", serr, berr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid_scan();
    logic [7:0] cap;
    set_board(8'hFF);
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midscan_busy: got %b expected 1", busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++; if ({coord_y, coord_x} !== 6'd0) begin fails++; $display("FAIL midscan_coord: got %0h expected 0", {coord_y, coord_x}); end
    tests++; if ({food_y, food_x} !== 6'd0) begin fails++; $display("FAIL midscan_food: got %0h expected 0", {food_y, food_x}); end
    tests++; if (food_valid !== 1'b0 || busy !== 1'b0 || board_full !== 1'b0) begin fails++; $display("FAIL midscan_flags: got valid=%b busy=%b full=%b expected 0 0 0", food_valid, busy, board_full); end
    tests++; if (m !== SEED) begin fails++; $display("FAIL midscan_model: got %0h expected %0h", m, SEED); end
    set_board(8'h00);
    cap = m;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    tick();
    tests++; if (food_valid !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL midscan_respawn: got valid=%b busy=%b expected 1 0", food_valid, busy); end
    tests++; if ({food_y, food_x} !== cap[5:0]) begin fails++; $display("FAIL midscan_pos: got %0h expected %0h", {food_y, food_x}, cap[5:0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cap;
    logic [5:0] first;
    int errs = 0;
    int distinct = 0;
    set_board(8'h00);
    first = '0;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < (i % 5); g++) tick();
      cap = m;
      spawn_req = 1'b1;
      tick();
      spawn_req = 1'b0;
      tick();
      if (food_valid !== 1'b1 || busy !== 1'b0 || {food_y, food_x} !== cap[5:0]) errs++;
      if (i == 0) first = {food_y, food_x};
      else if ({food_y, food_x} !== first) distinct++;
    end
    tests++; if (errs !== 0) begin fails++; $display("FAIL b2b_commit: got %0d bad commits expected 0", errs); end
    tests++; if (distinct == 0) begin fails++; $display("FAIL b2b_vary: got %0d differing positions expected >0", distinct); end
  endtask

  initial begin
    rst_n = 1'b0;
    spawn_req = 1'b0;
    set_board(8'h00);
    test_reset();
    test_empty_spawn();
    test_full_board();
    test_scan_find();
    test_ignored_requests();
    test_reset_mid_scan();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
